// File: rtl/image_block_loader.sv
// Image fetch engine: reads an imgSize x imgSize feature map word by word from
// data memory into a flat register buffer. Optional macro: IMAGE_LOADER_ZERO_FILL_EN.
module image_block_loader #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 16,
  parameter int MAX_DIM   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [ADDR_SIZE-1:0] loadImgAddress,
  input  logic [DATA_SIZE-1:0] imgSize,
  output logic                 memReadEnable,
  output logic [ADDR_SIZE-1:0] memAddr,
  input  logic                 memReadValid,
  input  logic [DATA_SIZE-1:0] memReadData,
  output logic [DATA_SIZE-1:0] fetchedImage [MAX_DIM*MAX_DIM],
  output logic                 loadImageDone,
  output logic                 loadError,
  output logic [2:0]           o_dbg_state
);

  localparam int DEPTH = MAX_DIM * MAX_DIM;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 2 * DATA_SIZE;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]           r_state;
  logic [2:0]           w_next_state;
  logic [ADDR_SIZE-1:0] r_base;
  logic [CNT_W-1:0]     r_total;
  logic [CNT_W-1:0]     r_k;
  logic                 r_err;
  logic [DATA_SIZE-1:0] r_buf [DEPTH];

  logic [CNT_W-1:0]     w_n_ext;
  logic [CNT_W-1:0]     w_total;
  logic [CNT_W-1:0]     w_k_inc;
  logic                 w_bad_size;
  logic                 w_start;
  logic                 w_wr;

  assign w_n_ext    = CNT_W'(imgSize);
  assign w_total    = w_n_ext * w_n_ext;
  assign w_k_inc    = r_k + 1'b1;
  assign w_bad_size = (imgSize == '0) || (imgSize > DATA_SIZE'(MAX_DIM));

  // Memory handshake: memReadEnable is a one-cycle request carrying memAddr;
  // exactly one request is outstanding, and its response is the next
  // memReadValid strobe (at least one cycle later). Strobes seen with no
  // request outstanding are dropped.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_wr         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_next_state = w_bad_size ? S_DONE : S_ISSUE;
          w_start      = !w_bad_size;
        end
      end
      S_ISSUE: begin
        w_next_state = enable ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (!enable) begin
          // A response landing on the abort cycle is discarded; nothing left to drain.
          w_next_state = memReadValid ? S_IDLE : S_DRAIN;
        end else if (memReadValid) begin
          w_wr         = 1'b1;
          w_next_state = (w_k_inc == r_total) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        if (!enable) w_next_state = S_IDLE;
      end
      S_DRAIN: begin
        if (memReadValid) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_total <= '0;
      r_k     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && enable) begin
        r_base  <= loadImgAddress;
        r_total <= w_total;
        r_k     <= '0;
        r_err   <= w_bad_size;
      end else if (w_wr) begin
        r_k <= w_k_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else begin
`ifdef IMAGE_LOADER_ZERO_FILL_EN
      if (w_start) begin
        for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      end
`endif
      if (w_wr) r_buf[r_k[IDX_W-1:0]] <= memReadData;
    end
  end

`ifndef IMAGE_LOADER_ZERO_FILL_EN
  logic w_start_unused;
  assign w_start_unused = w_start;
`endif

  assign memReadEnable = (r_state == S_ISSUE);
  assign memAddr       = memReadEnable ? (r_base + r_k[ADDR_SIZE-1:0]) : '0;
  assign loadImageDone = (r_state == S_DONE);
  assign loadError     = loadImageDone & r_err;
  assign fetchedImage  = r_buf;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_image_block_loader.sv
// Bench for image_block_loader: directed loads against a behavioural memory,
// with a queue-based monitor for read addresses and completion status.
module tb_image_block_loader;

  localparam int DS    = 16;
  localparam int AS    = 16;
  localparam int MD    = 32;
  localparam int DEPTH = MD * MD;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd4;

`ifdef IMAGE_LOADER_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          enable;
  logic [AS-1:0] loadImgAddress;
  logic [DS-1:0] imgSize;
  logic          memReadEnable;
  logic [AS-1:0] memAddr;
  logic          memReadValid;
  logic [DS-1:0] memReadData;
  logic [DS-1:0] fetchedImage [DEPTH];
  logic          loadImageDone;
  logic          loadError;
  logic [2:0]    o_dbg_state;

  image_block_loader #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .MAX_DIM(MD)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .loadImgAddress (loadImgAddress),
    .imgSize        (imgSize),
    .memReadEnable  (memReadEnable),
    .memAddr        (memAddr),
    .memReadValid   (memReadValid),
    .memReadData    (memReadData),
    .fetchedImage   (fetchedImage),
    .loadImageDone  (loadImageDone),
    .loadError      (loadError),
    .o_dbg_state    (o_dbg_state)
  );

  int checks = 0;
  int errors = 0;

  logic [AS-1:0] exp_q[$];
  logic [0:0]    exp_done_q[$];

  int            mem_lat  = 1;
  int            mem_mode = 0;
  logic [AS-1:0] mem_base = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DS-1:0] mem_data(input logic [AS-1:0] a);
    case (mem_mode)
      0:       return a ^ 16'h5A5A;
      1:       return a - mem_base + 16'd1;
      default: return 16'h0007;
    endcase
  endfunction

  // behavioural memory: answers each request after mem_lat cycles
  initial begin : memory_model
    logic [DS-1:0] d;
    memReadValid = 1'b0;
    memReadData  = '0;
    forever begin
      @(negedge clk);
      if (memReadEnable === 1'b1) begin
        d = mem_data(memAddr);
        @(posedge clk);
        repeat (mem_lat - 1) @(posedge clk);
        #1;
        memReadValid = 1'b1;
        memReadData  = d;
        @(posedge clk);
        #1;
        memReadValid = 1'b0;
      end
    end
  end

  // scoreboard monitor
  initial begin : monitor
    logic prev_done;
    logic [AS-1:0] ea;
    logic [0:0] ee;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (memReadEnable === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read actual=%0h expected=none", memAddr);
        end else begin
          ea = exp_q.pop_front();
          check("mem_addr", 32'(memAddr), 32'(ea));
        end
      end
      if (loadImageDone === 1'b1 && !prev_done) begin
        if (exp_done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          ee = exp_done_q.pop_front();
          check("done_error", 32'(loadError), 32'(ee));
        end
      end
      prev_done = (loadImageDone === 1'b1);
    end
  end

  // driver tasks
  task automatic push_load(input logic [AS-1:0] base, input int n);
    for (int i = 0; i < n * n; i++) exp_q.push_back(base + AS'(i));
    exp_done_q.push_back(1'b0);
  endtask

  task automatic start_load(input logic [AS-1:0] base, input int n, input int lat, input int mode);
    mem_lat        = lat;
    mem_mode       = mode;
    mem_base       = base;
    loadImgAddress = base;
    imgSize        = DS'(n);
    enable         = 1'b1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (loadImageDone !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (loadImageDone !== 1'b1) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=0 expected=1");
    end
  endtask

  task automatic finish_load();
    enable = 1'b0;
    @(posedge clk); #1;
    check("done_clear", 32'(loadImageDone), 32'd0);
  endtask

  function automatic int count_nonzero();
    int nz = 0;
    for (int i = 0; i < DEPTH; i++) if (fetchedImage[i] !== '0) nz++;
    return nz;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin : stimulus
    int cyc;
    int n;
    int sizes [2];
    logic [AS-1:0] a;
    reset          = 1'b0;
    enable         = 1'b0;
    loadImgAddress = '0;
    imgSize        = '0;
    #12;
    check("rst_read_en", 32'(memReadEnable), 32'd0);
    check("rst_done", 32'(loadImageDone), 32'd0);
    check("rst_error", 32'(loadError), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'(S_IDLE));
    check("rst_buf", 32'(count_nonzero()), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // size 3 at 0x0100, 1-cycle memory
    push_load(16'h0100, 3);
    start_load(16'h0100, 3, 1, 0);
    wait_done(cyc);
    check("latency_n3", 32'(cyc), 32'd19);
    check("n3_error", 32'(loadError), 32'd0);
    for (int i = 0; i < 9; i++)
      check("n3_entry", 32'(fetchedImage[i]), 32'((16'h0100 + 16'(i)) ^ 16'h5A5A));
    repeat (2) begin @(posedge clk); #1; end
    check("done_held", 32'(loadImageDone), 32'd1);
    check("buf_stable", 32'(fetchedImage[8]), 32'(16'h0108 ^ 16'h5A5A));
    finish_load();

    // illegal sizes
    sizes[0] = 0;
    sizes[1] = 33;
    for (int s = 0; s < 2; s++) begin
      exp_done_q.push_back(1'b1);
      start_load(16'h0700, sizes[s], 1, 0);
      @(posedge clk); #1;
      check("bad_done", 32'(loadImageDone), 32'd1);
      check("bad_error", 32'(loadError), 32'd1);
      @(posedge clk); #1;
      enable = 1'b0;
      @(posedge clk); #1;
      check("bad_done_clear", 32'(loadImageDone), 32'd0);
      check("bad_error_clear", 32'(loadError), 32'd0);
    end

    // address wrap
    push_load(16'hFFFE, 2);
    start_load(16'hFFFE, 2, 1, 0);
    wait_done(cyc);
    for (int i = 0; i < 4; i++) begin
      a = 16'hFFFE + 16'(i);
      check("wrap_entry", 32'(fetchedImage[i]), 32'(a ^ 16'h5A5A));
    end
    finish_load();

    // abort while 5th response pending, 3-cycle memory
    for (int i = 0; i < 5; i++) exp_q.push_back(16'h0200 + 16'(i));
    start_load(16'h0200, 4, 3, 0);
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
      if (memReadEnable === 1'b1) n++;
    end
    check("abort_reqs", 32'(n), 32'd5);
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    check("abort_drain", 32'(o_dbg_state), 32'(S_DRAIN));
    cyc = 0;
    while (o_dbg_state !== S_IDLE && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_idle", 32'(o_dbg_state), 32'(S_IDLE));
    check("abort_no_done", 32'(loadImageDone), 32'd0);
    for (int i = 0; i < 4; i++)
      check("abort_entry", 32'(fetchedImage[i]), 32'((16'h0200 + 16'(i)) ^ 16'h5A5A));
    check("abort_entry4", 32'(fetchedImage[4]), ZF ? 32'd0 : 32'(16'h0104 ^ 16'h5A5A));
    push_load(16'h0300, 2);
    start_load(16'h0300, 2, 1, 0);
    wait_done(cyc);
    check("reload_latency", 32'(cyc), 32'd9);
    for (int i = 0; i < 4; i++)
      check("reload_entry", 32'(fetchedImage[i]), 32'((16'h0300 + 16'(i)) ^ 16'h5A5A));
    finish_load();

    // stale entries beyond N*N
    push_load(16'h0400, 4);
    start_load(16'h0400, 4, 1, 1);
    wait_done(cyc);
    check("fill16_last", 32'(fetchedImage[15]), 32'd16);
    finish_load();
    push_load(16'h0500, 2);
    start_load(16'h0500, 2, 1, 2);
    wait_done(cyc);
    for (int i = 0; i < 4; i++)
      check("fill7_entry", 32'(fetchedImage[i]), 32'd7);
    for (int i = 4; i < 16; i++)
      check("fill_stale", 32'(fetchedImage[i]), ZF ? 32'd0 : 32'(i + 1));
    finish_load();

    // async reset in WAIT, between clock edges
    exp_q.push_back(16'h0600);
    start_load(16'h0600, 4, 3, 0);
    cyc = 0;
    while (o_dbg_state !== S_WAIT && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("pre_reset_wait", 32'(o_dbg_state), 32'(S_WAIT));
    #2;
    reset = 1'b0;
    #1;
    check("arst_state", 32'(o_dbg_state), 32'(S_IDLE));
    check("arst_read_en", 32'(memReadEnable), 32'd0);
    check("arst_addr", 32'(memAddr), 32'd0);
    check("arst_done", 32'(loadImageDone), 32'd0);
    check("arst_buf", 32'(count_nonzero()), 32'd0);
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    check("post_rst_idle", 32'(o_dbg_state), 32'(S_IDLE));
    check("post_rst_buf", 32'(count_nonzero()), 32'd0);

    check("addr_q_empty", 32'(exp_q.size()), 32'd0);
    check("done_q_empty", 32'(exp_done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
